// File: rtl/attention_pkg.sv
// rtl/attention_pkg.sv - shared constants, ordering key and buffer state type for the mask/row-max stage
//
// Purpose: FP32 special values, the total-order key used for the running
// maximum, a NaN test, and the per-buffer state enumeration.
// Ports: none (package).
package attention_pkg;

  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } buf_state_e;

  // Maps FP32 bit patterns onto an unsigned order: negatives are inverted so
  // larger magnitude sorts lower, positives get the top bit set so they sort
  // above every negative. -0 lands just below +0.
  function automatic logic [31:0] fp32_key(input logic [31:0] b);
    return b[31] ? ~b : {1'b1, b[30:0]};
  endfunction

  function automatic logic fp32_is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/attn_row_buf.sv
// rtl/attn_row_buf.sv - one ping-pong row bank with running max, NaN flag, tags and state
//
// Purpose: stores one masked score row, tracks the running maximum over
// unmasked elements and registers the final row max when the row completes.
// Ports:
//   clk, rst_n          clock, asynchronous active-high reset
//   wr_en_i             element write into this bank this cycle
//   wr_first_i/wr_end_i element is column 0 / column L-1
//   wr_col_i, wr_data_i, wr_masked_i  column, raw score, mask decision
//   wr_head_i, wr_row_i, wr_len_i     row tags and effective length
//   rd_hs_i, rd_end_i, rd_col_i       output handshake, last column, read column
//   state_o             bank state
//   rd_data_o, max_o, allmasked_o     stored element, row max, all-masked flag
//   head_o, row_o, len_o              tags captured on the first element
module attn_row_buf
  import attention_pkg::*;
#(
  parameter int T   = 8,
  parameter int T_W = 3,
  parameter int H_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic             wr_first_i,
  input  logic             wr_end_i,
  input  logic [T_W-1:0]   wr_col_i,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_masked_i,
  input  logic [H_W-1:0]   wr_head_i,
  input  logic [T_W-1:0]   wr_row_i,
  input  logic [T_W:0]     wr_len_i,
  input  logic             rd_hs_i,
  input  logic             rd_end_i,
  input  logic [T_W-1:0]   rd_col_i,
  output buf_state_e       state_o,
  output logic [31:0]      rd_data_o,
  output logic [31:0]      max_o,
  output logic             allmasked_o,
  output logic [H_W-1:0]   head_o,
  output logic [T_W-1:0]   row_o,
  output logic [T_W:0]     len_o
);

  logic [31:0]    mem_q [T];
  buf_state_e     state_q, state_d;
  logic [31:0]    best_q, best_d;
  logic           has_q, has_d;
  logic           nan_q, nan_d;
  logic [31:0]    max_q;
  logic           allm_q;
  logic [H_W-1:0] head_q;
  logic [T_W-1:0] row_q;
  logic [T_W:0]   len_q;
  logic           base_has, base_nan, take;

  // The first element of a row restarts the running max regardless of what a
  // previous row left in best_q; has_q says whether best_q is meaningful.
  always_comb begin
    base_has = wr_first_i ? 1'b0 : has_q;
    base_nan = wr_first_i ? 1'b0 : nan_q;
    take     = !wr_masked_i &&
               (!base_has || (fp32_key(wr_data_i) > fp32_key(best_q)));
    best_d   = take ? wr_data_i : best_q;
    has_d    = base_has | !wr_masked_i;
    nan_d    = base_nan | (!wr_masked_i && fp32_is_nan(wr_data_i));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:    if (wr_en_i) state_d = wr_end_i ? FULL : FILLING;
      FILLING:  if (wr_en_i && wr_end_i) state_d = FULL;
      FULL:     if (rd_hs_i) state_d = rd_end_i ? EMPTY : DRAINING;
      DRAINING: if (rd_hs_i && rd_end_i) state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= EMPTY;
      best_q  <= '0;
      has_q   <= 1'b0;
      nan_q   <= 1'b0;
      max_q   <= FP32_ZERO;
      allm_q  <= 1'b0;
      head_q  <= '0;
      row_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en_i) begin
        best_q <= best_d;
        has_q  <= has_d;
        nan_q  <= nan_d;
        if (wr_first_i) begin
          head_q <= wr_head_i;
          row_q  <= wr_row_i;
          len_q  <= wr_len_i;
        end
        if (wr_end_i) begin
          max_q  <= nan_d ? FP32_QNAN : (has_d ? best_d : FP32_ZERO);
          allm_q <= !has_d;
        end
      end
    end
  end

  // Row storage needs no reset: nothing is read until the bank reaches FULL.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_col_i] <= wr_masked_i ? FP32_NEG_INF : wr_data_i;
  end

  assign state_o     = state_q;
  assign rd_data_o   = mem_q[rd_col_i];
  assign max_o       = max_q;
  assign allmasked_o = allm_q;
  assign head_o      = head_q;
  assign row_o       = row_q;
  assign len_o       = len_q;

endmodule

// File: rtl/attention_mask_rowmax_mh.sv
// rtl/attention_mask_rowmax_mh.sv - multi-head streaming pad/causal mask and FP32 row-max stage
//
// Purpose: accepts score rows one element per cycle, masks pad and causal
// columns to -inf, finds the row max, and replays each row with the max
// attached through two ping-pong banks.
// Ports:
//   clk, rst_n                     clock, asynchronous active-high reset
//   cfg_len, pad_valid, causal_en  row length and mask controls
//   in_valid/in_ready, in_head, in_row, in_data, in_last   input stream
//   out_valid/out_ready, out_head, out_row, out_col, out_data, out_max,
//   out_last, out_allmasked        output stream
//   busy, err_last                 status
module attention_mask_rowmax_mh
  import attention_pkg::*;
#(
  parameter int T   = 8,
  parameter int NH  = 4,
  parameter int T_W = (T > 1) ? $clog2(T) : 1,
  parameter int H_W = (NH > 1) ? $clog2(NH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [T_W:0]     cfg_len,
  input  logic [T-1:0]     pad_valid,
  input  logic             causal_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [H_W-1:0]   in_head,
  input  logic [T_W-1:0]   in_row,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [H_W-1:0]   out_head,
  output logic [T_W-1:0]   out_row,
  output logic [T_W-1:0]   out_col,
  output logic [31:0]      out_data,
  output logic [31:0]      out_max,
  output logic             out_last,
  output logic             out_allmasked,
  output logic             busy,
  output logic             err_last
);

  localparam logic [T_W:0] T_LEN = (T_W + 1)'(T);

  logic           ready_en_q;
  logic           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [T_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [T_W:0]   wr_len_q, wr_len_d;
  logic [T_W-1:0] wr_row_q, wr_row_d;
  logic           err_last_q;

  logic [T_W:0]   cfg_eff, wr_len_eff;
  logic [T_W-1:0] wr_row_eff;
  logic           wr_first, wr_end, wr_masked, accept, rd_hs, rd_end;
  logic [1:0]     buf_wr_en, buf_rd_hs;

  buf_state_e     b_state [2];
  logic [31:0]    b_rdata [2];
  logic [31:0]    b_max   [2];
  logic           b_allm  [2];
  logic [H_W-1:0] b_head  [2];
  logic [T_W-1:0] b_row   [2];
  logic [T_W:0]   b_len   [2];

  // Length and row tag come from the live inputs on column 0 and from the
  // latched copies for the rest of the row.
  always_comb begin
    cfg_eff    = ((cfg_len == '0) || (cfg_len > T_LEN)) ? T_LEN : cfg_len;
    wr_first   = (wr_col_q == '0);
    wr_len_eff = wr_first ? cfg_eff : wr_len_q;
    wr_row_eff = wr_first ? in_row : wr_row_q;
    wr_end     = ({1'b0, wr_col_q} == (wr_len_eff - 1'b1));
    wr_masked  = !pad_valid[wr_col_q] || (causal_en && (wr_col_q > wr_row_eff));
    // ready_en_q keeps in_ready low until the first edge after reset release.
    in_ready   = ready_en_q &&
                 ((b_state[wr_ptr_q] == EMPTY) || (b_state[wr_ptr_q] == FILLING));
    accept     = in_valid && in_ready;
    out_valid  = (b_state[rd_ptr_q] == FULL) || (b_state[rd_ptr_q] == DRAINING);
    rd_end     = ({1'b0, rd_col_q} == (b_len[rd_ptr_q] - 1'b1));
    rd_hs      = out_valid && out_ready;
    buf_wr_en  = {accept && wr_ptr_q, accept && !wr_ptr_q};
    buf_rd_hs  = {rd_hs && rd_ptr_q, rd_hs && !rd_ptr_q};
  end

  always_comb begin
    wr_col_d = wr_col_q;
    wr_ptr_d = wr_ptr_q;
    wr_len_d = wr_len_q;
    wr_row_d = wr_row_q;
    rd_col_d = rd_col_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      if (wr_first) begin
        wr_len_d = cfg_eff;
        wr_row_d = in_row;
      end
      if (wr_end) begin
        wr_col_d = '0;
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end
    if (rd_hs) begin
      if (rd_end) begin
        rd_col_d = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ready_en_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_col_q   <= '0;
      rd_col_q   <= '0;
      wr_len_q   <= '0;
      wr_row_q   <= '0;
      err_last_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_col_q   <= wr_col_d;
      rd_col_q   <= rd_col_d;
      wr_len_q   <= wr_len_d;
      wr_row_q   <= wr_row_d;
      err_last_q <= accept && (in_last != wr_end);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_buf
    attn_row_buf #(
      .T   (T),
      .T_W (T_W),
      .H_W (H_W)
    ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (buf_wr_en[i]),
      .wr_first_i  (wr_first),
      .wr_end_i    (wr_end),
      .wr_col_i    (wr_col_q),
      .wr_data_i   (in_data),
      .wr_masked_i (wr_masked),
      .wr_head_i   (in_head),
      .wr_row_i    (in_row),
      .wr_len_i    (cfg_eff),
      .rd_hs_i     (buf_rd_hs[i]),
      .rd_end_i    (rd_end),
      .rd_col_i    (rd_col_q),
      .state_o     (b_state[i]),
      .rd_data_o   (b_rdata[i]),
      .max_o       (b_max[i]),
      .allmasked_o (b_allm[i]),
      .head_o      (b_head[i]),
      .row_o       (b_row[i]),
      .len_o       (b_len[i])
    );
  end

  // Outputs read zero whenever nothing is being presented, which also gives
  // the required all-zero values during reset.
  always_comb begin
    out_data      = out_valid ? b_rdata[rd_ptr_q] : '0;
    out_max       = out_valid ? b_max[rd_ptr_q]   : '0;
    out_head      = out_valid ? b_head[rd_ptr_q]  : '0;
    out_row       = out_valid ? b_row[rd_ptr_q]   : '0;
    out_col       = out_valid ? rd_col_q          : '0;
    out_last      = out_valid && rd_end;
    out_allmasked = out_valid && b_allm[rd_ptr_q];
    busy          = (b_state[0] != EMPTY) || (b_state[1] != EMPTY);
  end

  assign err_last = err_last_q;

endmodule

// File: tb/tb_attention_mask_rowmax_mh.sv
// tb/tb_attention_mask_rowmax_mh.sv - self-checking bench for attention_mask_rowmax_mh
module tb_attention_mask_rowmax_mh;

  localparam int T   = 8;
  localparam int NH  = 4;
  localparam int T_W = 3;
  localparam int H_W = 2;

  typedef struct packed {
    logic [H_W-1:0] head;
    logic [T_W-1:0] row;
    logic [T_W-1:0] col;
    logic [31:0]    data;
    logic [31:0]    mx;
    logic           last;
    logic           allm;
  } rec_t;

  logic             clk, rst_n;
  logic [T_W:0]     cfg_len;
  logic [T-1:0]     pad_valid;
  logic             causal_en, in_valid, in_ready, in_last;
  logic [H_W-1:0]   in_head;
  logic [T_W-1:0]   in_row;
  logic [31:0]      in_data;
  logic             out_valid, out_ready, out_last, out_allmasked, busy, err_last;
  logic [H_W-1:0]   out_head;
  logic [T_W-1:0]   out_row, out_col;
  logic [31:0]      out_data, out_max;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_cnt  = 0;
  int   exp_err  = 0;
  int   acc_cnt  = 0;
  int   last_cnt = 0;
  rec_t exp_q[$];
  rec_t rx_q[$];
  logic [31:0] rowd [8];

  attention_mask_rowmax_mh #(.T(T), .NH(NH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .pad_valid(pad_valid),
    .causal_en(causal_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_head(in_head), .in_row(in_row), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_head(out_head),
    .out_row(out_row), .out_col(out_col), .out_data(out_data), .out_max(out_max),
    .out_last(out_last), .out_allmasked(out_allmasked), .busy(busy),
    .err_last(err_last)
  );

  always #5 clk = ~clk;

  // Sample midway through the low phase, after the negedge drivers settle.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      if (out_valid && out_ready)
        rx_q.push_back(rec_t'{out_head, out_row, out_col, out_data, out_max,
                              out_last, out_allmasked});
      if (out_valid && out_ready && out_last) last_cnt++;
      if (in_valid && in_ready) acc_cnt++;
      if (err_last) err_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit f_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 0);
  endfunction

  // Numeric a > b for non-NaN floats, with -0 treated as below +0.
  function automatic bit f_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic void model_row(input int head, input int row, input int len,
                                    input logic [7:0] pad, input bit causal,
                                    input int last_col);
    bit          found = 0, nan = 0;
    bit          m [8];
    logic [31:0] best = 0, mx;
    rec_t        r;
    for (int c = 0; c < len; c++) begin
      m[c] = !pad[c] || (causal && c > row);
      if (!m[c]) begin
        if (f_nan(rowd[c])) nan = 1;
        if (!found || f_gt(rowd[c], best)) best = rowd[c];
        found = 1;
      end
    end
    mx = nan ? 32'h7FC00000 : (found ? best : 32'h0);
    for (int c = 0; c < len; c++) begin
      r.head = H_W'(head);
      r.row  = T_W'(row);
      r.col  = T_W'(c);
      r.data = m[c] ? 32'hFF800000 : rowd[c];
      r.mx   = mx;
      r.last = (c == len - 1);
      r.allm = !found;
      exp_q.push_back(r);
      if ((c == last_col) != (c == len - 1)) exp_err++;
    end
  endfunction

  function automatic logic [31:0] rnd_fp();
    int k = $urandom % 40;
    if (k == 0) return 32'h0000_0000;
    if (k == 1) return 32'h8000_0000;
    if (k == 2) return {1'b0, 8'hFF, 23'($urandom | 1)};
    if (k == 3) return 32'hFF80_0000;
    return {1'($urandom), 8'(120 + $urandom % 16), 23'($urandom)};
  endfunction

  // ---------------- drivers ----------------
  // Caller must be aligned to a negedge; returns at the negedge after the
  // final accept. nsend < 0 sends the full row and records expectations.
  task automatic send_row(input int head, input int row, input int cfg,
                          input logic [7:0] pad, input bit causal,
                          input int last_col, input int nsend);
    int len, n, k;
    len = (cfg == 0 || cfg > T) ? T : cfg;
    n   = (nsend < 0) ? len : nsend;
    if (nsend < 0) model_row(head, row, len, pad, causal, last_col);
    for (int c = 0; c < n; c++) begin
      in_valid  = 1;
      in_head   = H_W'(head);
      in_row    = T_W'(row);
      cfg_len   = (T_W + 1)'(cfg);
      pad_valid = pad;
      causal_en = causal;
      in_data   = rowd[c];
      in_last   = (c == last_col);
      k = 0;
      while (!in_ready && k < 500) begin @(negedge clk); k++; end
      if (!in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL send_row in_ready timeout: got %b required 1", in_ready);
        break;
      end
      @(negedge clk);
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_rx(output bit ok);
    int k = 0;
    while (rx_q.size() < exp_q.size() && k < 3000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    ok = (rx_q.size() == exp_q.size());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1; in_valid = 0; in_last = 0; out_ready = 0; cfg_len = 0;
    pad_valid = '1; causal_en = 0; in_head = 0; in_row = 0; in_data = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy, err_last, out_last, out_allmasked} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b required 000000",
               {in_ready, out_valid, busy, err_last, out_last, out_allmasked});
    end
    n_checks++;
    if ({out_data, out_max, out_head, out_row, out_col} !== '0) begin
      n_fail++;
      $display("FAIL reset data: got %h %h %h %h %h required zeros",
               out_data, out_max, out_head, out_row, out_col);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset in_ready before edge: got %b required 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic_max();
    bit ok; rec_t ex, rx;
    out_ready = 0;
    rowd = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h3F000000, 0, 0, 0, 0};
    send_row(0, 0, 4, 8'hFF, 0, 3, -1);
    n_checks++;
    if (out_valid !== 1'b1 || out_col !== 0 || out_max !== 32'h40400000) begin
      n_fail++;
      $display("FAIL basic latency: valid=%b col=%0d max=%h required 1 0 40400000",
               out_valid, out_col, out_max);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_col !== 0 || out_data !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL basic hold: valid=%b col=%0d data=%h required 1 0 3F800000",
               out_valid, out_col, out_data);
    end
    out_ready = 1;
    wait_rx(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ex = exp_q.pop_front(); rx = rx_q.pop_front(); n_checks++;
      if (rx !== ex) begin n_fail++; $display("FAIL basic elem: got %h required %h", rx, ex); end
    end
    exp_q.delete(); rx_q.delete();
    n_checks++;
    if (err_cnt !== exp_err) begin n_fail++; $display("FAIL basic err_last: got %0d required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_causal();
    bit ok; rec_t ex, rx;
    rowd = '{32'h40A00000, 32'h3F800000, 32'h40000000, 32'h41100000, 0, 0, 0, 0};
    send_row(1, 1, 4, 8'hFF, 1, 3, -1);
    wait_rx(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL causal count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ex = exp_q.pop_front(); rx = rx_q.pop_front(); n_checks++;
      if (rx !== ex) begin n_fail++; $display("FAIL causal elem: got %h required %h", rx, ex); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_pad_allmasked();
    bit ok; rec_t ex, rx;
    rowd = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h41000000, 0, 0, 0, 0};
    send_row(2, 3, 4, 8'h00, 0, 3, -1);
    rowd = '{32'hBF800000, 32'hC0400000, 32'h40E00000, 32'hBF000000, 0, 0, 0, 0};
    send_row(3, 0, 4, 8'h0B, 0, 3, -1);
    wait_rx(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pad count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ex = exp_q.pop_front(); rx = rx_q.pop_front(); n_checks++;
      if (rx !== ex) begin n_fail++; $display("FAIL pad elem: got %h required %h", rx, ex); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_boundaries();
    bit ok; rec_t ex, rx;
    for (int i = 0; i < 8; i++) rowd[i] = rnd_fp();
    rowd[0] = 32'h3F800000;
    send_row(0, 5, 0, 8'hFF, 0, 7, -1);            // cfg_len 0 -> full length
    for (int i = 0; i < 8; i++) rowd[i] = {1'b0, 8'(124 + i), 23'($urandom)};
    send_row(1, 2, 12, 8'hF7, 1, 7, -1);           // oversize cfg_len -> full length
    rowd = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h3E000000, 0, 0, 0, 0};
    send_row(2, 7, 4, 8'hFF, 0, 1, -1);            // early in_last at col 1
    rowd = '{32'h7FC00001, 32'h3F800000, 32'h40000000, 32'hBF800000, 0, 0, 0, 0};
    send_row(3, 0, 4, 8'hFF, 0, 3, -1);            // NaN at col 0
    rowd = '{32'h80000000, 32'h00000000, 32'h80000000, 0, 0, 0, 0, 0};
    send_row(0, 1, 3, 8'hFF, 0, 2, -1);            // -0 below +0
    rowd = '{32'h42000000, 0, 0, 0, 0, 0, 0, 0};
    send_row(1, 0, 1, 8'hFF, 0, 0, -1);            // single-element row
    wait_rx(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bound count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ex = exp_q.pop_front(); rx = rx_q.pop_front(); n_checks++;
      if (rx !== ex) begin n_fail++; $display("FAIL bound elem: got %h required %h", rx, ex); end
    end
    exp_q.delete(); rx_q.delete();
    n_checks++;
    if (err_cnt !== exp_err) begin n_fail++; $display("FAIL bound err_last: got %0d required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_back_to_back();
    bit ok, done, prev_hold;
    rec_t ex, rx, prev, cur;
    int acc0, last0, k, occ;
    acc0 = acc_cnt; last0 = last_cnt; done = 0; prev_hold = 0; prev = '0;
    out_ready = 0;
    fork
      begin
        for (int r = 0; r < 8; r++) begin
          for (int i = 0; i < 8; i++) rowd[i] = rnd_fp();
          send_row(r % 4, $urandom % 8, 4, 8'($urandom | 8'h01), 1'($urandom), 3, -1);
        end
      end
      begin
        k = 0;
        while (last_cnt < last0 + 8 && k < 3000) begin
          @(negedge clk);
          out_ready = !out_ready;
          #1;
          cur = rec_t'{out_head, out_row, out_col, out_data, out_max, out_last, out_allmasked};
          if (prev_hold) begin
            n_checks++;
            if (!out_valid || cur !== prev) begin
              n_fail++; $display("FAIL b2b stall hold: got %h required %h", cur, prev);
            end
          end
          occ = (acc_cnt - acc0 + 3) / 4 - (last_cnt - last0);
          if (in_valid && !in_ready) begin
            n_checks++;
            if (occ != 2) begin n_fail++; $display("FAIL b2b in_ready low: rows held %0d required 2", occ); end
          end
          prev = cur; prev_hold = out_valid && !out_ready;
          k++;
        end
      end
    join
    out_ready = 1;
    wait_rx(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ex = exp_q.pop_front(); rx = rx_q.pop_front(); n_checks++;
      if (rx !== ex) begin n_fail++; $display("FAIL b2b elem: got %h required %h", rx, ex); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_reset_midrow();
    bit ok; rec_t ex, rx;
    out_ready = 1;
    rowd = '{32'h44000000, 32'h45000000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0};
    send_row(1, 2, 4, 8'hFF, 0, 3, 2);
    rst_n = 1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, err_last, out_last, out_allmasked} !== 6'b0 ||
        {out_data, out_max, out_head, out_row, out_col} !== '0) begin
      n_fail++;
      $display("FAIL midrow reset: flags %b data %h max %h required zeros",
               {in_ready, out_valid, busy, err_last, out_last, out_allmasked}, out_data, out_max);
    end
    repeat (2) @(negedge clk);
    rst_n = 0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrow stale: outputs %0d valid %b busy %b required 0 0 0",
               rx_q.size(), out_valid, busy);
    end
    rx_q.delete();
    rowd = '{32'hC1000000, 32'h40400000, 32'h3F000000, 32'h40800000, 0, 0, 0, 0};
    send_row(2, 3, 4, 8'hFF, 0, 3, -1);
    wait_rx(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrow count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ex = exp_q.pop_front(); rx = rx_q.pop_front(); n_checks++;
      if (rx !== ex) begin n_fail++; $display("FAIL midrow elem: got %h required %h", rx, ex); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_random();
    bit ok, done; rec_t ex, rx;
    int cfg, len, lc;
    done = 0;
    fork
      begin
        for (int r = 0; r < 14; r++) begin
          for (int i = 0; i < 8; i++) rowd[i] = rnd_fp();
          cfg = $urandom % 16;
          len = (cfg == 0 || cfg > T) ? T : cfg;
          lc  = ($urandom % 4 == 0) ? int'($urandom % len) : len - 1;
          send_row($urandom % 4, $urandom % 8, cfg,
                   ($urandom % 3 == 0) ? 8'($urandom) : 8'hFF, 1'($urandom), lc, -1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom % 3) != 0;
        end
      end
    join
    out_ready = 1;
    wait_rx(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL random count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ex = exp_q.pop_front(); rx = rx_q.pop_front(); n_checks++;
      if (rx !== ex) begin n_fail++; $display("FAIL random elem: got %h required %h", rx, ex); end
    end
    exp_q.delete(); rx_q.delete();
    n_checks++;
    if (err_cnt !== exp_err) begin n_fail++; $display("FAIL random err_last: got %0d required %0d", err_cnt, exp_err); end
  endtask

  initial begin
    clk = 0;
    test_reset();
    test_basic_max();
    test_causal();
    test_pad_allmasked();
    test_boundaries();
    test_back_to_back();
    test_reset_midrow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
